// File: rtl/cache_dfp_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between the
// instruction cache (read-only) and the data cache (read/write).
// One transaction is in flight at a time; the downstream request is
// registered, and the memory response is routed back to its owner only.
module cache_dfp_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  // icache DFP
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_read,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  // dcache DFP
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  // memory side
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_read,
  output logic                  m_write,
  output logic [LINE_WIDTH-1:0] m_wdata,
  input  logic [LINE_WIDTH-1:0] m_rdata,
  input  logic                  m_resp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  // Clears the byte offset inside a 32-byte line.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-5){1'b1}}, 5'b0};

  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
    line_align = addr & LINE_MASK;
  endfunction

  state_t                state, state_nxt;
  logic                  last_d, last_d_nxt;   // 1: dcache was granted last
  logic                  req_i, req_d;
  logic                  grant_i, grant_d;
  logic [ADDR_WIDTH-1:0] m_addr_nxt;
  logic                  m_read_nxt, m_write_nxt;
  logic [LINE_WIDTH-1:0] m_wdata_nxt;

  // Requests are only looked at while idle; a tie goes to whoever was not served last.
  always_comb begin
    req_i   = i_read;
    req_d   = d_read | d_write;
    grant_i = (state == IDLE) && req_i && (!req_d || last_d);
    grant_d = (state == IDLE) && req_d && (!req_i || !last_d);
  end

  // Next-state and next memory-request computation.
  always_comb begin
    state_nxt   = state;
    last_d_nxt  = last_d;
    m_addr_nxt  = m_addr;
    m_read_nxt  = m_read;
    m_write_nxt = m_write;
    m_wdata_nxt = m_wdata;
    unique case (state)
      IDLE: begin
        if (grant_i) begin
          state_nxt   = BUSY_I;
          last_d_nxt  = 1'b0;
          m_addr_nxt  = line_align(i_addr);
          m_read_nxt  = 1'b1;
          m_write_nxt = 1'b0;
          m_wdata_nxt = '0;
        end else if (grant_d) begin
          // A writeback takes precedence if both d_read and d_write are high.
          state_nxt   = BUSY_D;
          last_d_nxt  = 1'b1;
          m_addr_nxt  = line_align(d_addr);
          m_read_nxt  = !d_write;
          m_write_nxt = d_write;
          m_wdata_nxt = d_write ? d_wdata : '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_resp) begin
          state_nxt   = IDLE;
          m_addr_nxt  = '0;
          m_read_nxt  = 1'b0;
          m_write_nxt = 1'b0;
          m_wdata_nxt = '0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        m_addr_nxt  = '0;
        m_read_nxt  = 1'b0;
        m_write_nxt = 1'b0;
        m_wdata_nxt = '0;
      end
    endcase
  end

  // State, round-robin pointer and registered memory request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last_d  <= 1'b1;
      m_addr  <= '0;
      m_read  <= 1'b0;
      m_write <= 1'b0;
      m_wdata <= '0;
    end else begin
      state   <= state_nxt;
      last_d  <= last_d_nxt;
      m_addr  <= m_addr_nxt;
      m_read  <= m_read_nxt;
      m_write <= m_write_nxt;
      m_wdata <= m_wdata_nxt;
    end
  end

  // Response routing: data goes to both, only the owner's resp qualifies it.
  always_comb begin
    i_rdata = m_rdata;
    d_rdata = m_rdata;
    i_resp  = (state == BUSY_I) && m_resp;
    d_resp  = (state == BUSY_D) && m_resp;
  end

endmodule
